muldiv_hilo_ctrl: RTL and testbench



---
 rtl/muldiv_hilo_ctrl_if.sv | 42 ++++
 rtl/muldiv_hilo_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_ctrl_if.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_ctrl_if
//
// Purpose: groups the EX-stage issue signals and the HI/LO result signals
// exchanged between the pipeline and the multiply/divide sequencer.
//
// Signals:
//   start        pipeline -> seq  HI/LO-class instruction present in EX
//   op[2:0]      pipeline -> seq  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//   a[31:0]      pipeline -> seq  rs operand (already forwarded)
//   b[31:0]      pipeline -> seq  rt operand (already forwarded)
//   flush        pipeline -> seq  exception/ERET flush
//   stall        seq -> pipeline  combinational hold of IF/ID/EX
//   hi[31:0]     seq -> pipeline  architectural HI
//   lo[31:0]     seq -> pipeline  architectural LO
//   done         seq -> pipeline  one-cycle pulse, new HI/LO visible
//   div_by_zero  seq -> pipeline  pulse with done for a divide by zero
//
// Modports: master = pipeline side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface muldiv_hilo_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        div_by_zero;

    modport master (
        output start, op, a, b, flush,
        input  stall, hi, lo, done, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall, hi, lo, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_ctrl
//
// Purpose: multi-cycle multiply/divide sequencer owning the architectural
// HI/LO pair of a 5-stage MIPS pipeline. Multiplies take a fixed MUL_LAT
// busy cycles after issue; divides run a 32-iteration restoring divider on
// operand magnitudes followed by a sign-fixup/commit cycle. MTHI/MTLO write
// directly without stalling. Any in-flight operation can be cancelled by
// flush, in which case HI/LO are left untouched.
//
// Ports:
//   clk   input  rising-edge clock
//   rst   input  synchronous, active-high reset
//   bus   slave modport of muldiv_hilo_ctrl_if (start/op/a/b/flush in,
//         stall/hi/lo/done/div_by_zero out)
//
// Parameters:
//   MUL_LAT  busy cycles of a multiply after its issue cycle (1..8)
//
// Build option:
//   MULDIV_EARLY_OUT_EN  when defined, a divide whose dividend magnitude is
//                        below the divisor magnitude skips the iterations
//                        and commits quotient 0 / remainder a after FIX.
// ---------------------------------------------------------------------------
module muldiv_hilo_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_hilo_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        dbz_q;

    // Operand A register doubles as the divide quotient shift register;
    // operand B register holds the divisor magnitude during a divide.
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [31:0] rem_q;
    logic        mul_signed_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dbz_pend_q;

    // -----------------------------------------------------------------------
    // Issue decode
    // -----------------------------------------------------------------------
    logic        issue_ok;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        early_out;

    // The done cycle is excluded so the instruction still held in EX during
    // its own completion cycle is not taken a second time.
    assign issue_ok   = (state_q == S_IDLE) && bus.start && !done_q && !bus.flush;

    assign div_signed = (bus.op == OP_DIV);
    assign a_neg      = div_signed & bus.a[31];
    assign b_neg      = div_signed & bus.b[31];
    assign a_mag      = a_neg ? (32'd0 - bus.a) : bus.a;
    assign b_mag      = b_neg ? (32'd0 - bus.b) : bus.b;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out  = (b_mag != 32'd0) && (a_mag < b_mag);
`else
    assign early_out  = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Multiply datapath: the low 64 bits of a 64x64 product of sign- or
    // zero-extended operands equal the signed or unsigned 32x32 product.
    // -----------------------------------------------------------------------
    logic [63:0] mul_a_ext;
    logic [63:0] mul_b_ext;
    logic [63:0] mul_prod;

    assign mul_a_ext = {{32{mul_signed_q & opa_q[31]}}, opa_q};
    assign mul_b_ext = {{32{mul_signed_q & opb_q[31]}}, opb_q};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    // -----------------------------------------------------------------------
    // Restoring divide step. The partial remainder is always below the
    // divisor, so after the shift it is below twice the divisor: bit 32 of
    // the trial difference is therefore a clean borrow flag, and when there
    // is no borrow the difference fits in 32 bits.
    // -----------------------------------------------------------------------
    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic        sub_ok;

    assign rem_shift = {rem_q, opa_q[31]};
    assign rem_sub   = rem_shift - {1'b0, opb_q};
    assign sub_ok    = ~rem_sub[32];

    // Sign fixup: quotient negative when operand signs differ, remainder
    // follows the dividend.
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;

    assign quo_fixed = q_neg_q ? (32'd0 - opa_q) : opa_q;
    assign rem_fixed = r_neg_q ? (32'd0 - rem_q) : rem_q;

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 5'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            done_q       <= 1'b0;
            dbz_q        <= 1'b0;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            rem_q        <= 32'd0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            dbz_pend_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;

            if (bus.flush) begin
                // Cancel whatever is in flight; HI/LO keep their old value.
                state_q <= S_IDLE;
                cnt_q   <= 5'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (issue_ok) begin
                            case (bus.op)
                                OP_MULT, OP_MULTU: begin
                                    opa_q        <= bus.a;
                                    opb_q        <= bus.b;
                                    mul_signed_q <= (bus.op == OP_MULT);
                                    cnt_q        <= MUL_CNT_INIT;
                                    state_q      <= S_MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    q_neg_q    <= a_neg ^ b_neg;
                                    r_neg_q    <= a_neg;
                                    opb_q      <= b_mag;
                                    dbz_pend_q <= 1'b0;
                                    cnt_q      <= 5'd0;
                                    if (bus.b == 32'd0) begin
                                        // No iterations; FIX only raises the flag.
                                        dbz_pend_q <= 1'b1;
                                        opa_q      <= 32'd0;
                                        rem_q      <= 32'd0;
                                        state_q    <= S_FIX;
                                    end else if (early_out) begin
                                        opa_q      <= 32'd0;
                                        rem_q      <= a_mag;
                                        state_q    <= S_FIX;
                                    end else begin
                                        opa_q      <= a_mag;
                                        rem_q      <= 32'd0;
                                        cnt_q      <= 5'd31;
                                        state_q    <= S_DIV;
                                    end
                                end
                                OP_MTHI: begin
                                    hi_q   <= bus.a;
                                    done_q <= 1'b1;
                                end
                                OP_MTLO: begin
                                    lo_q   <= bus.a;
                                    done_q <= 1'b1;
                                end
                                default: begin
                                    // Codes 6/7: no stall, no write, no done.
                                end
                            endcase
                        end
                    end

                    S_MUL: begin
                        if (cnt_q == 5'd0) begin
                            hi_q    <= mul_prod[63:32];
                            lo_q    <= mul_prod[31:0];
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end

                    S_DIV: begin
                        rem_q <= sub_ok ? rem_sub[31:0] : rem_shift[31:0];
                        opa_q <= {opa_q[30:0], sub_ok};
                        if (cnt_q == 5'd0) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end

                    S_FIX: begin
                        if (dbz_pend_q) begin
                            dbz_q <= 1'b1;
                        end else begin
                            hi_q <= rem_fixed;
                            lo_q <= quo_fixed;
                        end
                        dbz_pend_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_IDLE;
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Issue-cycle stall only for multiply/divide codes (op <= 3).
    assign bus.stall       = !bus.flush &&
                             ((state_q != S_IDLE) ||
                              (bus.start && !done_q && !bus.op[2]));
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
`timescale 1ns/1ps
module tb_muldiv_hilo_ctrl;

    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    // Reference architectural state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_txn = 0;

    muldiv_hilo_ctrl_if bus();

    muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: plain arithmetic on the architectural rules.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int stall_cycles, output logic dbz);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        lat = -1;
        stall_cycles = 0;
        dbz = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin
                p = 64'(sx * sy);
                m_hi = p[63:32]; m_lo = p[31:0];
                lat = MUL_LAT + 1; stall_cycles = MUL_LAT + 1;
            end
            3'd1: begin
                p = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32]; m_lo = p[31:0];
                lat = MUL_LAT + 1; stall_cycles = MUL_LAT + 1;
            end
            3'd2, 3'd3: begin
                if (y == 32'd0) begin
                    dbz = 1'b1;
                    lat = 2; stall_cycles = 2;
                end else begin
                    if (o == 3'd2) begin
                        q = sx / sy; r = sx % sy;
                    end else begin
                        q = longint'(x) / longint'(y); r = longint'(x) % longint'(y);
                    end
                    m_lo = q[31:0]; m_hi = r[31:0];
                    lat = 34; stall_cycles = 34;
`ifdef MULDIV_EARLY_OUT_EN
                    if (q == 0) begin
                        lat = 2; stall_cycles = 2;
                    end
`endif
                end
            end
            3'd4: begin m_hi = x; lat = 1; end
            3'd5: begin m_lo = x; lat = 1; end
            default: ;
        endcase
    endtask

    // Issue one instruction, holding start while stall is high and through
    // the first non-stalled cycle, as the pipeline does.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int   t;
        int   lat;
        int   exp_stall;
        int   n_stall;
        logic dbz;
        exp_t e;
        bit   ended;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        t = cyc;
        model(o, x, y, lat, exp_stall, dbz);
        if (lat >= 0) begin
            e.hi = m_hi; e.lo = m_lo; e.dbz = dbz; e.cyc = t + lat;
            exp_q.push_back(e);
        end
        n_stall = 0;
        ended = 0;
        for (int k = 0; k < 100 && !ended; k++) begin
            @(negedge clk);
            if (bus.stall) begin
                n_stall++;
                @(posedge clk); #1;
            end else begin
                ended = 1;
            end
        end
        if (!ended) begin
            n_total++;
            $display("FAIL stall_timeout: stall still high after 100 cycles, required release (op %0d)", o);
        end
        chk("stall_cycles", 64'(n_stall), 64'(exp_stall));
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Issue an operation and flush it k cycles after the issue cycle.
    task automatic flush_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int k);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        repeat (k) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_hi", 64'(bus.hi), 64'(m_hi));
        chk("flush_lo", 64'(bus.lo), 64'(m_lo));
        chk("flush_idle_stall", 64'(bus.stall), 64'd0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("hi", 64'(bus.hi), 64'(mon_e.hi));
                    chk("lo", 64'(bus.lo), 64'(mon_e.lo));
                    chk("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dbz));
                    n_txn++;
                    $display("txn %0d @%0d: hi=%08h lo=%08h dbz=%b", n_txn, cyc, bus.hi, bus.lo, bus.div_by_zero);
                end
            end else if (bus.div_by_zero) begin
                n_total++;
                $display("FAIL dbz_without_done: div_by_zero=1 done=0 at cycle %0d, required both or neither", cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);
        chk("reset_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(bus.lo), 64'h0000_0001);

        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("divu_lo", 64'(bus.lo), 64'h7FFF_FFFC);
        chk("divu_hi", 64'(bus.hi), 64'h0000_0001);

        do_op(3'd4, 32'h11, 32'd0);
        do_op(3'd5, 32'h22, 32'd0);
        do_op(3'd2, 32'd5, 32'd0);
        chk("dbz_hi", 64'(bus.hi), 64'h11);
        chk("dbz_lo", 64'(bus.lo), 64'h22);

        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_lo", 64'(bus.lo), 64'h8000_0000);
        chk("ovf_hi", 64'(bus.hi), 64'd0);

        flush_op(3'd3, 32'd100, 32'd7, 20);
        do_op(3'd0, 32'd6, 32'd7);
        chk("post_flush_hi", 64'(bus.hi), 64'd0);
        chk("post_flush_lo", 64'(bus.lo), 64'd42);

        // Flush in the multiply commit cycle
        flush_op(3'd0, 32'd9, 32'd9, MUL_LAT);

        do_op(3'd3, 32'd3, 32'd10);
        chk("small_divu_lo", 64'(bus.lo), 64'd0);
        chk("small_divu_hi", 64'(bus.hi), 64'd3);

        do_op(3'd6, 32'd1, 32'd2);
        do_op(3'd7, 32'd3, 32'd4);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 5));
            rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1, 2:    ry = 32'($urandom_range(1, 50));
                3:       ry = 32'hFFFF_FFFF;
                default: ry = $urandom;
            endcase
            do_op(ro, rx, ry);
        end

        // Reset in the middle of a multiply: no partial update, HI/LO cleared.
        do_op(3'd4, 32'hDEAD_BEEF, 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        chk("midop_reset_hi", 64'(bus.hi), 64'(m_hi));
        chk("midop_reset_lo", 64'(bus.lo), 64'(m_lo));
        chk("midop_reset_stall", 64'(bus.stall), 64'd0);

        repeat (40) @(posedge clk);
        #1;
        chk("pending_expectations", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
